// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Priority states, port identifiers and width defaults.
package dmem_arbiter_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    typedef enum logic {
        S_P0PRI,
        S_P1PRI
    } state_e;

    typedef enum logic {
        PORT0,
        PORT1
    } port_e;

endpackage

// File: rtl/dmem_resp_pipe.sv
// Read-response pipe: valid/tag/data shift register.
// The last stage steers the response to its owning port.
module dmem_resp_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_tag,
    input  logic [DW-1:0] in_data,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata
);

    logic [STAGES-1:0] sv;
    port_e             st [STAGES];
    logic [DW-1:0]     sd [STAGES];
    logic [DW-1:0]     hold0;
    logic [DW-1:0]     hold1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv    <= '0;
            hold0 <= '0;
            hold1 <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st[k] <= PORT0;
                sd[k] <= '0;
            end
        end else begin
            sv[0] <= in_valid;
            st[0] <= port_e'(in_tag);
            sd[0] <= in_data;
            for (int k = 1; k < STAGES; k++) begin
                sv[k] <= sv[k-1];
                st[k] <= st[k-1];
                sd[k] <= sd[k-1];
            end
            if (p0_rvalid)
                hold0 <= sd[STAGES-1];
            if (p1_rvalid)
                hold1 <= sd[STAGES-1];
        end
    end

    // Data is shown live on the pulse, then held until the next response.
    assign p0_rvalid = sv[STAGES-1] && (st[STAGES-1] == PORT0);
    assign p1_rvalid = sv[STAGES-1] && (st[STAGES-1] == PORT1);
    assign p0_rdata  = p0_rvalid ? sd[STAGES-1] : hold0;
    assign p1_rdata  = p1_rvalid ? sd[STAGES-1] : hold1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory.
// Port 0 has priority; port 1 is forced through after MAX_WAIT refusals.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int MAX_WAIT    = 4,
    parameter int RESP_STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          d_mem_write_en,
    output logic          d_mem_read,
    output logic [AW-1:0] d_mem_addr,
    output logic [DW-1:0] d_mem_write_data,
    input  logic [DW-1:0] d_mem_read_data
);

    localparam logic [3:0] MAXW = 4'(MAX_WAIT);

    state_e     state;
    state_e     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_P0PRI;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        wait_nxt  = wait_cnt;
        state_nxt = state;

        if (!rst) begin
            unique case (state)
                S_P0PRI: begin
                    p0_gnt = p0_req;
                    p1_gnt = p1_req && !p0_req;
                end
                S_P1PRI: begin
                    p1_gnt = p1_req;
                    p0_gnt = p0_req && !p1_req;
                end
            endcase
        end

        if (!p1_req || p1_gnt)
            wait_nxt = '0;
        else if (wait_cnt != MAXW)
            wait_nxt = wait_cnt + 4'd1;

        // Switch on the edge where the refusal count hits the limit.
        unique case (state)
            S_P0PRI: if (wait_nxt == MAXW) state_nxt = S_P1PRI;
            S_P1PRI: if (p1_gnt || !p1_req) state_nxt = S_P0PRI;
        endcase
    end

    always_comb begin
        d_mem_write_en   = 1'b0;
        d_mem_read       = 1'b0;
        d_mem_addr       = '0;
        d_mem_write_data = '0;
        if (p0_gnt) begin
            d_mem_write_en   = p0_we;
            d_mem_read       = !p0_we;
            d_mem_addr       = p0_addr;
            d_mem_write_data = p0_wdata;
        end else if (p1_gnt) begin
            d_mem_write_en   = p1_we;
            d_mem_read       = !p1_we;
            d_mem_addr       = p1_addr;
            d_mem_write_data = p1_wdata;
        end
    end

    dmem_resp_pipe #(
        .DW     (DW),
        .STAGES (RESP_STAGES)
    ) u_resp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_mem_read),
        .in_tag    (p1_gnt),
        .in_data   (d_mem_read_data),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata)
    );

endmodule
